// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: locks onto an incoming hs/vs raster and regenerates pixel position,
// video_on and frame_start with one clock of latency; flags and counts timing violations.
module vga_sync_decoder #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int ERR_W     = 8
) (
    input  logic             clock_25,
    input  logic             reset_key,
    input  logic             vga_hs,
    input  logic             vga_vs,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             video_on,
    output logic             locked,
    output logic             frame_start,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int TO_W    = $clog2(2 * H_TOTAL);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(2 * H_TOTAL - 1);

    typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

    state_t            state_q, state_d;
    logic              hs_q, vs_q;
    logic [9:0]        h_q, h_d, v_q, v_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  cnt_q, cnt_d;

    logic       hs_fall, hs_rise, vs_fall, vs_rise, h_wrap, timeout, viol;
    logic [9:0] h_nat, v_nat;

    always_comb begin
        hs_fall = hs_q & ~vga_hs;
        hs_rise = ~hs_q & vga_hs;
        vs_fall = vs_q & ~vga_vs;
        vs_rise = ~vs_q & vga_vs;
        h_nat   = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        h_d     = hs_fall ? HS_START : h_nat;
        h_wrap  = !hs_fall && (h_q == H_LAST);
        v_nat   = h_wrap ? ((v_q == V_LAST) ? 10'd0 : v_q + 10'd1) : v_q;
        timeout = !hs_fall && (to_q == TO_LAST);
        to_d    = (hs_fall || timeout) ? '0 : to_q + 1'b1;
        // Checks compare against where the free-running counters would land this cycle
        viol    = (hs_fall && h_nat != HS_START) ||
                  (hs_rise && h_nat != HS_END) ||
                  (vs_fall && (v_nat != VS_START || h_d != 10'd0)) ||
                  (vs_rise && (v_nat != VS_END || h_d != 10'd0));
        err_d   = (state_q == LOCKED) && (viol || timeout);
        state_d = timeout ? SEARCH :
                  (state_q == LOCKED) ? (viol ? (hs_fall ? HLOCK : SEARCH) : LOCKED) :
                  (state_q == HLOCK || hs_fall) ? (vs_fall ? LOCKED : HLOCK) : SEARCH;
        v_d     = (state_d != LOCKED) ? 10'd0 : vs_fall ? VS_START : v_nat;
        cnt_d   = (err_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock_25) begin
        if (!reset_key) begin
            state_q <= SEARCH;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            h_q     <= '0;
            v_q     <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hs_q    <= vga_hs;
            vs_q    <= vga_vs;
            h_q     <= h_d;
            v_q     <= v_d;
            to_q    <= to_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign locked      = (state_q == LOCKED);
    assign video_on    = locked && (h_q < H_VIS) && (v_q < V_VIS);
    assign frame_start = locked && (h_q == 10'd0) && (v_q == 10'd0);
    assign sync_err    = err_q;
    assign err_count   = cnt_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a scaled-down raster into two decoders (ERR_W 8 and 2) and
// scores every cycle against expectations derived from the generator position.
module tb_vga_sync_decoder;
    localparam int HV = 16, HF = 2, HSY = 4, HB = 3, HT = HV + HF + HSY + HB;
    localparam int VV = 6, VF = 1, VSY = 2, VB = 2, VT = VV + VF + VSY + VB;
    localparam int HSS = HV + HF, VSS = VV + VF, FRAME = HT * VT;

    logic clk = 1'b0, rst_n = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [9:0] px, py, px2, py2;
    logic von, lck, fs, err, von2, lck2, fs2, err2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    vga_sync_decoder #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
                       .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .ERR_W(8)) dut (
        .clock_25(clk), .reset_key(rst_n), .vga_hs(hs), .vga_vs(vs),
        .pixel_x(px), .pixel_y(py), .video_on(von), .locked(lck),
        .frame_start(fs), .sync_err(err), .err_count(cnt));

    vga_sync_decoder #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
                       .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .ERR_W(2)) dut2 (
        .clock_25(clk), .reset_key(rst_n), .vga_hs(hs), .vga_vs(vs),
        .pixel_x(px2), .pixel_y(py2), .video_on(von2), .locked(lck2),
        .frame_start(fs2), .sync_err(err2), .err_count(cnt2));

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x, y;
        logic       von, lck, fs, err;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic       chk_xy;
    } exp_t;

    typedef struct {
        int kind;
        int c8;
        int c2;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[5];
    int gh = 0, gv = 0, mode = 0, phase = 0, nofall = 0;
    int ecnt = 0, ecnt2 = 0, fs_seen = 0, errors = 0, checks = 0;
    logic phs = 1'b1, pvs = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // One pixel: drive syncs (with optional fault), predict, clock, compare.
    task automatic step(input logic r);
        logic h, v, hf, vf, inj, to, e;
        exp_t ex;
        h   = !(gh >= HSS && gh < HSS + HSY);
        v   = !(gv >= VSS && gv < VSS + VSY);
        inj = 1'b0;
        case (mode)
            1: if (gv == 2) begin h = !(gh >= HSS && gh < HSS + HSY - 1); inj = (gh == HSS + HSY - 1); end
            2: if (gv == 2) begin h = !(gh >= HSS && gh <= HSS + HSY); inj = (gh == HSS + HSY + 1); end
            3: if (gv == 2) begin h = !(gh >= HSS - 1 && gh < HSS + HSY); inj = (gh == HSS - 1); end
            4: if (gv == VSS) begin v = (gh == 0); inj = (gh == 1); end
            5: if (gv == 1 || gv == 2) begin h = 1'b1; v = 1'b1; end
            default: ;
        endcase
        hs = h; vs = v; rst_n = r;
        if (!r) begin
            phase = 0; nofall = 0; ecnt = 0; ecnt2 = 0; phs = 1'b1; pvs = 1'b1;
            ex = '{10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1};
        end else begin
            hf = phs & ~h; vf = pvs & ~v; phs = h; pvs = v;
            nofall = hf ? 0 : nofall + 1;
            to = (nofall == 2 * HT);
            if (to) nofall = 0;
            e = (phase == 2) && (inj || to);
            if (e) begin
                ecnt  = (ecnt < 255) ? ecnt + 1 : ecnt;
                ecnt2 = (ecnt2 < 3) ? ecnt2 + 1 : ecnt2;
                phase = hf ? 1 : 0;
            end else if (to) phase = 0;
            else if (phase == 0 && hf) phase = 1;
            else if (phase == 1 && vf) phase = 2;
            ex.x = 10'(gh); ex.y = 10'(gv);
            ex.lck = (phase == 2);
            ex.von = ex.lck && gh < HV && gv < VV;
            ex.fs  = ex.lck && gh == 0 && gv == 0;
            ex.err = e; ex.cnt = 8'(ecnt); ex.cnt2 = 2'(ecnt2); ex.chk_xy = ex.lck;
        end
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        checks++;
        if ((ex.chk_xy && (px !== ex.x || py !== ex.y)) || von !== ex.von || lck !== ex.lck ||
            fs !== ex.fs || err !== ex.err || cnt !== ex.cnt || cnt2 !== ex.cnt2 || lck2 !== ex.lck) begin
            errors++;
            $display("FAIL cycle gen=(%0d,%0d): got x=%0d y=%0d von=%b lck=%b fs=%b err=%b cnt=%0d cnt2=%0d want x=%0d y=%0d von=%b lck=%b fs=%b err=%b cnt=%0d cnt2=%0d",
                     gh, gv, px, py, von, lck, fs, err, cnt, cnt2,
                     ex.x, ex.y, ex.von, ex.lck, ex.fs, ex.err, ex.cnt, ex.cnt2);
        end
        if (fs) fs_seen++;
        gh = (gh == HT - 1) ? 0 : gh + 1;
        if (gh == 0) gv = (gv == VT - 1) ? 0 : gv + 1;
    endtask

    task automatic to_frame();
        while (gh != 0 || gv != 0) step(1'b1);
    endtask

    task automatic inject(input int k);
        mode = k;
        repeat (FRAME) step(1'b1);
        mode = 0;
        repeat (FRAME) step(1'b1);
    endtask

    initial begin
        tbl[0] = '{1, 1, 1};
        tbl[1] = '{2, 2, 2};
        tbl[2] = '{3, 3, 3};
        tbl[3] = '{4, 4, 3};
        tbl[4] = '{5, 5, 3};
        repeat (3) step(1'b0);
        repeat (FRAME) step(1'b1);
        to_frame();
        fs_seen = 0;
        repeat (2 * FRAME) step(1'b1);
        chk("frame_start_per_2_frames", fs_seen, 2);
        inject(1);
        chk("short_hs_err_count", int'(cnt), 1);
        chk("short_hs_relocked", int'(lck), 1);
        inject(5);
        chk("timeout_err_count", int'(cnt), 2);
        chk("timeout_relocked", int'(lck), 1);
        while (!(gv == 3 && gh == 10)) step(1'b1);
        step(1'b0);
        chk("reset_err_count", int'(cnt), 0);
        chk("reset_pixel_x", int'(px), 0);
        repeat (FRAME) step(1'b1);
        to_frame();
        chk("reset_relocked", int'(lck), 1);
        for (int i = 0; i < 5; i++) begin
            inject(tbl[i].kind);
            chk($sformatf("vec%0d_err_count8", i), int'(cnt), tbl[i].c8);
            chk($sformatf("vec%0d_err_count2", i), int'(cnt2), tbl[i].c2);
            chk($sformatf("vec%0d_relocked", i), int'(lck), 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
